// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: pipeline vs. loader/debug access, single shared port.
// Define DM_ARB_FAIRNESS_EN to enable the loader wait counter and forced grant.
module dm_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk_n,
    input  logic        rst,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [6:0]  p_addr,
    input  logic [15:0] p_din,
    output logic        p_stall,
    output logic [15:0] p_dout,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [6:0]  l_addr,
    input  logic [15:0] l_din,
    output logic        l_ack,
    output logic [15:0] l_dout,
    output logic        dm_wea,
    output logic [6:0]  dm_addra,
    output logic [15:0] dm_dina,
    input  logic [15:0] dm_douta
);

    // state  | meaning
    // L_IDLE | loader may be granted this cycle
    // L_ACK  | loader was granted last cycle; l_ack and read data presented
    typedef enum logic {L_IDLE, L_ACK} lstate_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_LOAD} owner_t;

    lstate_t state_q, state_d;
    owner_t  owner;
    logic    force_grant;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_check
        $error("dm_arbiter: MAX_WAIT must be in 1..15");
    end

`ifdef DM_ARB_FAIRNESS_EN
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [3:0] wait_q, wait_d;

    assign force_grant = (wait_q >= MAX_WAIT_L);

    always_comb begin
        wait_d = wait_q;
        if (!l_req || owner == OWN_LOAD) begin
            wait_d = 4'd0;
        end else if (state_q == L_IDLE && wait_q != 4'd15) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign force_grant = 1'b0;
`endif

    // Ownership is suppressed during reset so the memory port is quiet immediately.
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            if (state_q == L_IDLE) begin
                if (force_grant && l_req) begin
                    owner = OWN_LOAD;
                end else if (p_req) begin
                    owner = OWN_PIPE;
                end else if (l_req) begin
                    owner = OWN_LOAD;
                end
            end else if (p_req) begin
                owner = OWN_PIPE;
            end
        end
    end

    always_comb begin
        state_d = L_IDLE;
        if (owner == OWN_LOAD) begin
            state_d = L_ACK;
        end
    end

    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            state_q <= L_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        dm_wea   = 1'b0;
        dm_addra = p_addr;
        dm_dina  = p_din;
        case (owner)
            OWN_PIPE: dm_wea = p_we;
            OWN_LOAD: begin
                dm_wea   = l_we;
                dm_addra = l_addr;
                dm_dina  = l_din;
            end
            default: dm_wea = 1'b0;
        endcase
    end

    assign p_stall = p_req && (owner != OWN_PIPE) && !rst;
    assign l_ack   = (state_q == L_ACK);
    assign l_dout  = dm_douta;
    assign p_dout  = dm_douta;

endmodule
